wb_stage: RTL and testbench

Write-back stage of the RISC-V pipeline: the producer side of the register file write port. It registers the MEM-stage result (the MEM/WB pipeline register), extracts and extends load data, selects the result source, and drives the register file write port. The register file commits on the falling edge, so a result is readable by decode within the same cycle. It also flags faulting loads and maintains the retired-instruction counter.

---
 rtl/wb_stage.sv | 102 ++++++++++
 tb/tb_wb_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, load formatting, result select,
// register file write port, load-fault flag and retired-instruction counter.
module wb_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 64
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_valid,
    input  logic                  i_flush,
    input  logic                  i_reg_wr,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    input  logic [1:0]            i_result_src,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic [DATA_WIDTH-1:0] i_pc_plus4,
    input  logic [DATA_WIDTH-1:0] i_imm,
    input  logic [2:0]            i_load_funct3,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_load_fault,
    output logic [CNT_WIDTH-1:0]  o_instret
);

    logic                  valid_q, valid_d;
    logic                  reg_wr_q, reg_wr_d;
    logic                  fault_q, fault_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]  instret_q, instret_d;

    logic [1:0]            off;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic                  ld_illegal;
    logic                  ld_misal;
    logic                  take;
    logic [DATA_WIDTH-1:0] load_data;

    always_comb begin
        off        = i_alu_result[1:0];
        byte_v     = i_mem_rdata[{off, 3'b000} +: 8];
        half_v     = i_mem_rdata[{off[1], 4'b0000} +: 16];
        ld_illegal = (i_load_funct3 == 3'b011) || (i_load_funct3 == 3'b110)
                  || (i_load_funct3 == 3'b111);
        ld_misal   = ((i_load_funct3[1:0] == 2'b01) && off[0])
                  || ((i_load_funct3 == 3'b010) && (off != 2'b00));
        take       = i_valid & ~i_flush;

        load_data = i_mem_rdata;
        unique case (i_load_funct3)
            3'b000:  load_data = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
            3'b001:  load_data = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
            3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, byte_v};
            3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, half_v};
            default: load_data = i_mem_rdata;
        endcase

        data_d = i_alu_result;
        unique case (i_result_src)
            2'b01:   data_d = load_data;
            2'b10:   data_d = i_pc_plus4;
            2'b11:   data_d = i_imm;
            default: data_d = i_alu_result;
        endcase

        valid_d  = take;
        reg_wr_d = i_reg_wr;
        rd_d     = i_rd_addr;
        fault_d  = take && (i_result_src == 2'b01) && (ld_illegal || ld_misal);

        // a faulting instruction occupies WB but never retires
        instret_d = instret_q + CNT_WIDTH'(valid_q & ~fault_q);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q   <= 1'b0;
            reg_wr_q  <= 1'b0;
            fault_q   <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
            instret_q <= '0;
        end else begin
            valid_q   <= valid_d;
            reg_wr_q  <= reg_wr_d;
            fault_q   <= fault_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            instret_q <= instret_d;
        end
    end

    assign o_wr_en      = valid_q & reg_wr_q & (rd_q != '0) & ~fault_q;
    assign o_wr_addr    = rd_q;
    assign o_wr_data    = data_q;
    assign o_load_fault = valid_q & fault_q;
    assign o_instret    = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage; a second 3-bit-counter instance checks wrap.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        valid, flush, reg_wr;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [31:0] alu, rdata, pc4, imm;
    logic [2:0]  f3;

    logic        wr_en, fault;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [63:0] instret;

    logic        s_wr_en, s_fault;
    logic [4:0]  s_wr_addr;
    logic [31:0] s_wr_data;
    logic [2:0]  s_instret;

    int n_cmp = 0;
    int n_bad = 0;

    wb_stage dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .i_flush(flush),
        .i_reg_wr(reg_wr), .i_rd_addr(rd), .i_result_src(src),
        .i_alu_result(alu), .i_mem_rdata(rdata), .i_pc_plus4(pc4),
        .i_imm(imm), .i_load_funct3(f3), .o_wr_en(wr_en),
        .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_load_fault(fault), .o_instret(instret)
    );

    wb_stage #(.CNT_WIDTH(3)) dut_w (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .i_flush(flush),
        .i_reg_wr(reg_wr), .i_rd_addr(rd), .i_result_src(src),
        .i_alu_result(alu), .i_mem_rdata(rdata), .i_pc_plus4(pc4),
        .i_imm(imm), .i_load_funct3(f3), .o_wr_en(s_wr_en),
        .o_wr_addr(s_wr_addr), .o_wr_data(s_wr_data),
        .o_load_fault(s_fault), .o_instret(s_instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic fl, input logic w,
                         input logic [4:0] r, input logic [1:0] s,
                         input logic [31:0] a, input logic [2:0] f);
        valid  = v;
        flush  = fl;
        reg_wr = w;
        rd     = r;
        src    = s;
        alu    = a;
        f3     = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [2:0]  f;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t ld_tab[5];

    initial begin
        ld_tab[0] = '{32'h3, 3'b000, 32'hFFFF_FF80};
        ld_tab[1] = '{32'h3, 3'b100, 32'h0000_0080};
        ld_tab[2] = '{32'h2, 3'b001, 32'hFFFF_80FF};
        ld_tab[3] = '{32'h0, 3'b101, 32'h0000_7F01};
        ld_tab[4] = '{32'h0, 3'b010, 32'h80FF_7F01};

        rst_n = 1'b0;
        rdata = 32'h80FF_7F01;
        pc4   = 32'h0000_1004;
        imm   = 32'hABCD_E000;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 3'b000);
        step();
        step();
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_addr", 64'(wr_addr), 64'd0);
        check("rst_data", 64'(wr_data), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_instret", instret, 64'd0);
        rst_n = 1'b1;

        drive(1'b1, 1'b0, 1'b1, 5'd5, 2'b00, 32'h1234_5678, 3'b000);
        step();
        check("alu_wr_en", 64'(wr_en), 64'd1);
        check("alu_addr", 64'(wr_addr), 64'd5);
        check("alu_data", 64'(wr_data), 64'h1234_5678);
        check("alu_cnt0", instret, 64'd0);
        drive(1'b1, 1'b0, 1'b1, 5'd6, 2'b00, 32'hAAAA_5555, 3'b000);
        step();
        check("b2b_addr", 64'(wr_addr), 64'd6);
        check("b2b_data", 64'(wr_data), 64'hAAAA_5555);
        check("b2b_cnt1", instret, 64'd1);
        drive(1'b0, 1'b0, 1'b1, 5'd6, 2'b00, 32'h0, 3'b000);
        step();
        check("bub_wr_en", 64'(wr_en), 64'd0);
        check("bub_cnt2", instret, 64'd2);

        drive(1'b1, 1'b0, 1'b1, 5'd8, 2'b10, 32'h0, 3'b000);
        step();
        check("pc4_data", 64'(wr_data), 64'h0000_1004);
        check("pc4_cnt", instret, 64'd2);
        drive(1'b1, 1'b0, 1'b1, 5'd9, 2'b11, 32'h0, 3'b000);
        step();
        check("imm_data", 64'(wr_data), 64'hABCD_E000);
        check("imm_cnt", instret, 64'd3);

        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b1, 5'd10, 2'b01, ld_tab[i].a, ld_tab[i].f);
            step();
            check($sformatf("ld%0d_data", i), 64'(wr_data), 64'(ld_tab[i].exp));
            check($sformatf("ld%0d_wr_en", i), 64'(wr_en), 64'd1);
            check($sformatf("ld%0d_cnt", i), instret, 64'(4 + i));
        end

        drive(1'b1, 1'b0, 1'b1, 5'd11, 2'b01, 32'h2, 3'b010);
        step();
        check("mis_fault", 64'(fault), 64'd1);
        check("mis_wr_en", 64'(wr_en), 64'd0);
        check("mis_cnt", instret, 64'd9);
        drive(1'b1, 1'b0, 1'b1, 5'd12, 2'b01, 32'h0, 3'b011);
        step();
        check("ill_fault", 64'(fault), 64'd1);
        check("ill_wr_en", 64'(wr_en), 64'd0);
        check("ill_cnt", instret, 64'd9);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 3'b000);
        step();
        check("flt_pulse_end", 64'(fault), 64'd0);
        check("flt_no_cnt", instret, 64'd9);

        drive(1'b1, 1'b0, 1'b1, 5'd0, 2'b00, 32'h55, 3'b000);
        step();
        check("x0_wr_en", 64'(wr_en), 64'd0);
        drive(1'b1, 1'b0, 1'b0, 5'd9, 2'b00, 32'h66, 3'b000);
        step();
        check("st_wr_en", 64'(wr_en), 64'd0);
        check("x0_cnt", instret, 64'd10);
        drive(1'b0, 1'b0, 1'b1, 5'd9, 2'b00, 32'h0, 3'b000);
        step();
        check("st_cnt", instret, 64'd11);
        drive(1'b1, 1'b1, 1'b1, 5'd7, 2'b01, 32'h1, 3'b010);
        step();
        check("fl_wr_en", 64'(wr_en), 64'd0);
        check("fl_fault", 64'(fault), 64'd0);
        check("fl_cnt", instret, 64'd11);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 3'b000);
        step();
        check("fl_no_cnt", instret, 64'd11);

        drive(1'b1, 1'b0, 1'b1, 5'd3, 2'b00, 32'hDEAD_BEEF, 3'b000);
        step();
        check("pre_rst_wr_en", 64'(wr_en), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_wr_en", 64'(wr_en), 64'd0);
        check("arst_addr", 64'(wr_addr), 64'd0);
        check("arst_data", 64'(wr_data), 64'd0);
        check("arst_fault", 64'(fault), 64'd0);
        check("arst_cnt", instret, 64'd0);
        step();
        rst_n = 1'b1;

        drive(1'b1, 1'b0, 1'b1, 5'd1, 2'b00, 32'h1, 3'b000);
        for (int i = 0; i < 8; i++) step();
        check("wrap_full", 64'(s_instret), 64'd7);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 3'b000);
        step();
        check("wrap_zero", 64'(s_instret), 64'd0);
        check("wrap_big", instret, 64'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
